// File: rtl/spi_master_oversampled.sv
// SPI mode-0 master: SCK by integer division of clk_in, MISO captured through a
// 2-FF synchronizer a fixed number of clk_in cycles into each SCK-high phase.
module spi_master_oversampled #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 5,
    parameter int SAMPLE_DLY = 3,
    parameter int CS_SETUP   = 4,
    parameter int CS_HOLD    = 4,
    parameter int CS_IDLE    = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_cs,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int M1      = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int M2      = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(CS_HOLD - 1);
    // The IDLE cycle in which the next start is taken is part of the CS-high gap,
    // so GAP itself runs one cycle short of CS_IDLE.
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(CS_IDLE - 2);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_W - 1);

    if (DATA_W < 2) begin : g_bad_data_w
        $error("DATA_W must be >= 2");
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("CLK_DIV must be >= 2");
    end
    if (SAMPLE_DLY < 1 || SAMPLE_DLY > CLK_DIV) begin : g_bad_sample_dly
        $error("SAMPLE_DLY must satisfy 1 <= SAMPLE_DLY <= CLK_DIV");
    end
    if (CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1) begin : g_bad_cs
        $error("CS_SETUP, CS_HOLD and CS_IDLE must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              miso_m;
    logic              miso_s;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            miso_m   <= 1'b0;
            miso_s   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            spi_cs   <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            miso_m <= spi_miso;
            miso_s <= miso_m;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tx_sh    <= tx_data;
                        spi_mosi <= tx_data[DATA_W-1];
                        spi_cs   <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt     <= '0;
                        spi_sck <= 1'b1;
                        state   <= SCK_HI;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SCK_HI: begin
                    if (cnt == SAMPLE_LAST) begin
                        rx_sh <= {rx_sh[DATA_W-2:0], miso_s};
                    end
                    if (cnt == DIV_LAST) begin
                        cnt     <= '0;
                        spi_sck <= 1'b0;
                        state   <= SCK_LO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SCK_LO: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= HOLD;
                        end else begin
                            // MOSI moves on the same edge SCK rises, i.e. never mid-high.
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            tx_sh    <= {tx_sh[DATA_W-2:0], 1'b0};
                            spi_mosi <= tx_sh[DATA_W-2];
                            spi_sck  <= 1'b1;
                            state    <= SCK_HI;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= '0;
                        spi_cs   <= 1'b1;
                        done     <= 1'b1;
                        rx_data  <= rx_sh;
                        spi_mosi <= 1'b0;
                        if (CS_IDLE == 1) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_oversampled.sv
// Directed bench for spi_master_oversampled: loopback, skewed and glitchy slave,
// ignored start, back-to-back frames and asynchronous reset mid-frame.
module tb_spi_master_oversampled;

    localparam int CLK_DIV = 5;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       spi_cs;
    logic       spi_sck;
    logic       spi_mosi;
    logic       miso_pin;

    logic       loopback;
    logic       miso_drv = 1'b0;
    logic [1:0] slave_mode;
    logic [7:0] slave_word;
    logic [2:0] sidx = 3'd0;
    logic [2:0] cur  = 3'd0;

    int n_pass  = 0;
    int n_total = 0;

    int cyc = 0, cs_run = 0, hi_run = 0, last_cs_low = 0, last_cs_high = 0;
    int sck_rises = 0, rises_in_frame = 0, last_rise = 0;
    int spacing_bad = 0, mosi_bad = 0, done_cnt = 0;
    logic prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;

    int b_rise, b_sp, b_mo, b_done, n;

    assign miso_pin = loopback ? spi_mosi : miso_drv;

    spi_master_oversampled dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .spi_cs  (spi_cs),
        .spi_sck (spi_sck),
        .spi_mosi(spi_mosi),
        .spi_miso(miso_pin)
    );

    always #20 clk_in = ~clk_in;

    // Bus monitor, sampled on the inactive edge.
    initial forever begin
        @(negedge clk_in);
        cyc++;
        if (spi_cs === 1'b0) begin
            if (prev_cs) begin
                last_cs_high   = hi_run;
                rises_in_frame = 0;
                cs_run         = 0;
            end
            cs_run++;
        end else begin
            if (!prev_cs) begin
                last_cs_low = cs_run;
                hi_run      = 0;
            end
            hi_run++;
        end
        if (spi_sck === 1'b1 && !prev_sck) begin
            if (spi_cs === 1'b0 && rises_in_frame > 0 && (cyc - last_rise) != 2 * CLK_DIV)
                spacing_bad++;
            rises_in_frame++;
            sck_rises++;
            last_rise = cyc;
        end
        if (prev_sck && spi_sck === 1'b1 && spi_mosi !== prev_mosi) mosi_bad++;
        if (done === 1'b1) done_cnt++;
        prev_cs   = spi_cs;
        prev_sck  = spi_sck;
        prev_mosi = spi_mosi;
    end

    // Slave model: mode 1 changes MISO 20 ns after each SCK rise, mode 2 drives an
    // inverted glitch for most of the first high cycle before settling.
    initial forever begin
        @(posedge spi_sck or negedge spi_cs);
        if (spi_sck !== 1'b1) begin
            sidx = 3'd0;
        end else begin
            cur  = sidx;
            sidx = sidx + 3'd1;
            if (slave_mode == 2'd1) begin
                #20 miso_drv = slave_word[3'd7 - cur];
            end else if (slave_mode == 2'd2) begin
                #1  miso_drv = ~slave_word[3'd7 - cur];
                #29 miso_drv = slave_word[3'd7 - cur];
            end
        end
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_frame(input logic [7:0] w);
        @(posedge clk_in);
        #1 tx_data = w;
        start = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k;
        k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (done !== 1'b1 && k < max);
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        tx_data    = 8'h00;
        loopback   = 1'b1;
        slave_mode = 2'd0;
        slave_word = 8'h00;

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_cs",   32'(spi_cs),   32'd1);
        check("rst_sck",  32'(spi_sck),  32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_done", 32'(done),     32'd0);
        check("rst_rx",   32'(rx_data),  32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk_in);

        // Loopback A5 with frame timing checks
        b_rise = sck_rises; b_sp = spacing_bad; b_mo = mosi_bad; b_done = done_cnt;
        run_frame(8'hA5);
        wait_done("t1_done", 200);
        check("t1_rx",        32'(rx_data), 32'hA5);
        check("t1_cs_at_done", 32'(spi_cs), 32'd1);
        check("t1_busy_at_done", 32'(busy), 32'd1);
        repeat (8) @(negedge clk_in);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_cs_low_len", last_cs_low, 32'd88);
        check("t1_sck_rises", sck_rises - b_rise, 32'd8);
        check("t1_rise_spacing", spacing_bad - b_sp, 32'd0);
        check("t1_mosi_stable", mosi_bad - b_mo, 32'd0);
        check("t1_done_count", done_cnt - b_done, 32'd1);

        // Skewed slave returning 3C
        loopback = 1'b0; slave_mode = 2'd1; slave_word = 8'h3C;
        run_frame(8'h00);
        wait_done("t2_done", 200);
        check("t2_rx", 32'(rx_data), 32'h3C);
        repeat (8) @(negedge clk_in);

        // Glitching slave returning 96
        slave_mode = 2'd2; slave_word = 8'h96;
        run_frame(8'h00);
        wait_done("t3_done", 200);
        check("t3_rx", 32'(rx_data), 32'h96);
        repeat (8) @(negedge clk_in);

        // Second start mid-frame is ignored
        loopback = 1'b1; slave_mode = 2'd0;
        b_done = done_cnt;
        run_frame(8'hC3);
        repeat (19) @(posedge clk_in);
        #1 tx_data = 8'hFF;
        start = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
        wait_done("t4_done", 200);
        check("t4_rx", 32'(rx_data), 32'hC3);
        repeat (12) @(negedge clk_in);
        check("t4_done_count", done_cnt - b_done, 32'd1);
        check("t4_busy_after", 32'(busy), 32'd0);

        // Back-to-back frames with start held high
        b_done = done_cnt;
        @(posedge clk_in);
        #1 tx_data = 8'h81;
        start = 1'b1;
        wait_done("t5_done1", 200);
        check("t5_rx1", 32'(rx_data), 32'h81);
        tx_data = 8'h7E;
        wait_done("t5_done2", 200);
        check("t5_rx2", 32'(rx_data), 32'h7E);
        check("t5_cs_gap", last_cs_high, 32'd4);
        start = 1'b0;
        repeat (12) @(negedge clk_in);
        check("t5_done_count", done_cnt - b_done, 32'd2);
        check("t5_busy_after", 32'(busy), 32'd0);

        // Asynchronous reset during bit 3 (MOSI and SCK both high at that point)
        b_rise = sck_rises; b_done = done_cnt;
        run_frame(8'hF0);
        n = 0;
        while ((sck_rises - b_rise) < 4 && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        check("t6_reach_bit3", 32'(sck_rises - b_rise), 32'd4);
        check("t6_pre_sck", 32'(spi_sck), 32'd1);
        #5 rst = 1'b0;
        #1;
        check("t6_cs",   32'(spi_cs),   32'd1);
        check("t6_sck",  32'(spi_sck),  32'd0);
        check("t6_mosi", 32'(spi_mosi), 32'd0);
        check("t6_busy", 32'(busy),     32'd0);
        check("t6_done", 32'(done),     32'd0);
        check("t6_rx",   32'(rx_data),  32'd0);
        repeat (4) @(negedge clk_in);
        rst = 1'b1;
        repeat (4) @(negedge clk_in);
        check("t6_no_done", done_cnt - b_done, 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);
        run_frame(8'h5A);
        wait_done("t6_done_after", 200);
        check("t6_rx_after", 32'(rx_data), 32'h5A);
        repeat (8) @(negedge clk_in);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
